ecg_cfg_seq: RTL
================

Name: ecg_cfg_seq

Overview:
- Sequencer between the stimulus/ROM stream source and the feature extractor core.
- Parses the config word stream (magic, length, parameters, checksum) and writes parameters into the extractor parameter register file.
- Once config is accepted, forwards ECG samples through a small FIFO to the extractor using valid/ready.
- Source streams have no backpressure, so the block detects and flags overflow.

Parameters:
- DATA_W, 16, width of config words and samples
- PRM_AW, 6, parameter address width; max parameter count is 2^PRM_AW
- FIFO_DEPTH, 4, sample FIFO entries (power of 2)
- LOG2_FIFO, 2, log2(FIFO_DEPTH)
- CFG_MAGIC, 16'hC0F6, required first config word
- SMP_CNT_W, 13, width of the accepted-sample counter

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- cfg_en_i  in  1  config word valid this cycle
- cfg_data_i  in  DATA_W  config word
- ecg_en_i  in  1  ECG sample valid this cycle
- ecg_data_i  in  DATA_W  ECG sample
- prm_we_o  out  1  parameter write strobe
- prm_addr_o  out  PRM_AW  parameter address
- prm_data_o  out  DATA_W  parameter data
- smp_valid_o  out  1  FIFO head valid
- smp_data_o  out  DATA_W  FIFO head data
- smp_ready_i  in  1  extractor accepts head
- cfg_ok_o  out  1  config accepted (sticky)
- cfg_err_o  out  1  config rejected (sticky)
- ovf_o  out  1  sample dropped, FIFO full (sticky)
- smp_cnt_o  out  SMP_CNT_W  samples pushed into the FIFO, saturating

Behaviour:
- Reset: state = HDR; every output = 0; FIFO empty; checksum = 0; parameter counter = 0.
- State HDR, on a cfg word:
  - word == CFG_MAGIC: go to LEN.
  - Otherwise: go to ERR.
- State LEN, on a cfg word, latch N = word:
  - N > 2^PRM_AW: go to ERR.
  - N == 0: go to CHK.
  - Otherwise: go to PRM.
- State PRM, per cfg word:
  - Assert prm_we_o for exactly one cycle in the cycle after the word, with prm_addr_o = index (0..N-1) and prm_data_o = word. Latency is 1 cycle.
  - Add the word to the 16-bit checksum, modulo 2^16.
  - After the N-th word, go to CHK.
- State CHK, on a cfg word:
  - word == checksum: go to STRM; cfg_ok_o = 1 on the next cycle.
  - Otherwise: go to ERR; cfg_err_o = 1.
  - The checksum covers parameter words only (not magic, length or checksum).
- State STRM:
  - Each ecg_en_i pushes ecg_data_i into the FIFO.
  - Additional cfg words are ignored.
- State ERR:
  - Terminal; all cfg and ecg input is ignored.
  - No further prm_we_o.
  - Only reset exits.
- cfg_en_i gaps, i.e. idle cycles between words, are legal in every state; state only advances on qualified words.
- ecg_en_i outside STRM is ignored: no push, no count.
- FIFO behaviour:
  - First-word-fall-through: smp_valid_o = !empty; smp_data_o = head.
  - Pop when smp_valid_o && smp_ready_i.
  - Push at full with no pop in the same cycle: sample dropped, ovf_o set, smp_cnt_o not incremented.
  - Push and pop in the same cycle at full: both occur, no overflow.
  - Push and pop in the same cycle at empty: the pushed word appears on smp_data_o the following cycle. No combinational bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- smp_cnt_o: increments per accepted push; saturates at 2^SMP_CNT_W - 1.
- Async reset mid-operation:
  - Immediately clears state, FIFO, flags and counters.
  - prm_we_o deasserts without completing a write.

Optional Feature:
- Macro: ECG_CFG_CHKSUM_EN.
- Defined: CHK state and checksum verification as described.
- Undefined:
  - No checksum word in the stream.
  - PRM (or LEN with N == 0) goes directly to STRM.
  - cfg_ok_o is set when the last parameter is written, or after LEN when N == 0.
  - The checksum accumulator is not built.

Test Plan:
- Magic C0F6, N=3, params 0001 0002 0003, checksum 0006 -> three prm_we_o pulses at addr 0,1,2 with data 1,2,3; cfg_ok_o=1; cfg_err_o=0.
- First word 1234 -> cfg_err_o=1; no prm_we_o; subsequent 10 ECG samples give smp_valid_o=0 and smp_cnt_o=0.
- Magic, N=2, params FFFF 0002, checksum 0001 -> ok (16-bit wrap); with checksum 0002 instead -> cfg_err_o=1 after 2 writes.
- Magic, N=65 (PRM_AW=6) -> cfg_err_o=1 with no writes. Magic, N=0, checksum 0000 -> cfg_ok_o=1.
- STRM, smp_ready_i=0, 6 back-to-back samples 10..15 -> FIFO holds 10..13; ovf_o=1; smp_cnt_o=4. Then ready=1 -> pops 10,11,12,13 in order.
- STRM, ready=1 continuously, 100 samples with random gaps -> output order and data match input; ovf_o=0; smp_cnt_o=100. Reset asserted mid-stream -> all outputs 0 and state HDR.

Source files
------------

// File: rtl/ecg_cfg_seq.sv
`timescale 1ns/1ps
// ecg_cfg_seq
// ----------------------------------------------------------------------------
// Sequencer between the stimulus/ROM stream source and the ECG feature
// extractor. It parses the configuration word stream (magic, length,
// parameters and an optional checksum) and writes each parameter into the
// extractor parameter register file. Once the configuration is accepted, it
// forwards ECG samples to the extractor through a small
// first-word-fall-through FIFO. The sources cannot be stalled, so a sample
// that arrives while the FIFO is full is dropped and flagged.
//
// Build option:
//   ECG_CFG_CHKSUM_EN  defined   : a checksum word follows the parameters and
//                                  must equal the 16-bit sum of the parameters.
//                      undefined : no checksum word; streaming starts right
//                                  after the last parameter (or after a zero
//                                  length).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_en_i/cfg_data_i   config word strobe and data (no backpressure)
//   ecg_en_i/ecg_data_i   ECG sample strobe and data (no backpressure)
//   prm_we_o/addr/data    one-cycle parameter write, one cycle after the word
//   smp_valid_o/data_o    FIFO head towards the extractor
//   smp_ready_i           extractor accepts the head
//   cfg_ok_o, cfg_err_o   sticky config accepted / rejected
//   ovf_o                 sticky: a sample was dropped at a full FIFO
//   smp_cnt_o             saturating count of samples pushed into the FIFO
//   state_o               sequencer state, for observation only
//
// Handshake: the head word transfers on every rising clk edge where
// smp_valid_o && smp_ready_i; smp_valid_o never depends on smp_ready_i and
// the head stays stable until it transfers.
// ----------------------------------------------------------------------------
module ecg_cfg_seq #(
    parameter int                DATA_W     = 16,
    parameter int                PRM_AW     = 6,
    parameter int                FIFO_DEPTH = 4,
    parameter int                LOG2_FIFO  = 2,
    parameter logic [DATA_W-1:0] CFG_MAGIC  = 16'hC0F6,
    parameter int                SMP_CNT_W  = 13
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_en_i,
    input  logic [DATA_W-1:0]    cfg_data_i,
    input  logic                 ecg_en_i,
    input  logic [DATA_W-1:0]    ecg_data_i,
    output logic                 prm_we_o,
    output logic [PRM_AW-1:0]    prm_addr_o,
    output logic [DATA_W-1:0]    prm_data_o,
    output logic                 smp_valid_o,
    output logic [DATA_W-1:0]    smp_data_o,
    input  logic                 smp_ready_i,
    output logic                 cfg_ok_o,
    output logic                 cfg_err_o,
    output logic                 ovf_o,
    output logic [SMP_CNT_W-1:0] smp_cnt_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LEN  = 3'd1,
        S_PRM  = 3'd2,
        S_CHK  = 3'd3,
        S_STRM = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Where the parser goes once the parameter list is complete.
`ifdef ECG_CFG_CHKSUM_EN
    localparam state_t AFTER_PRM = S_CHK;
`else
    localparam state_t AFTER_PRM = S_STRM;
`endif

    // Largest legal length value: the full parameter address space.
    localparam logic [DATA_W-1:0] PRM_MAX = DATA_W'(1 << PRM_AW);
    localparam logic [PRM_AW:0]   PRM_ONE = (PRM_AW + 1)'(1);
    localparam logic [LOG2_FIFO:0] PTR_ONE = (LOG2_FIFO + 1)'(1);
    localparam logic [SMP_CNT_W-1:0] CNT_ONE = SMP_CNT_W'(1);
    localparam logic [SMP_CNT_W-1:0] CNT_MAX = {SMP_CNT_W{1'b1}};

    state_t state, state_nxt;

    // Parameter index and latched length are one bit wider than the address
    // so that a full 2^PRM_AW list can be represented.
    logic [PRM_AW:0] prm_cnt;
    logic [PRM_AW:0] prm_len;
    logic            last_prm;

`ifdef ECG_CFG_CHKSUM_EN
    logic [DATA_W-1:0] chksum;
`endif

    // FIFO pointers carry one wrap bit to tell full from empty.
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [LOG2_FIFO:0] wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop, drop;

    assign state_o  = state;
    assign last_prm = ((prm_cnt + PRM_ONE) == prm_len);

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: begin
                if (cfg_en_i) begin
                    state_nxt = (cfg_data_i == CFG_MAGIC) ? S_LEN : S_ERR;
                end
            end
            S_LEN: begin
                if (cfg_en_i) begin
                    if (cfg_data_i > PRM_MAX) begin
                        state_nxt = S_ERR;
                    end else if (cfg_data_i == '0) begin
                        state_nxt = AFTER_PRM;
                    end else begin
                        state_nxt = S_PRM;
                    end
                end
            end
            S_PRM: begin
                if (cfg_en_i && last_prm) begin
                    state_nxt = AFTER_PRM;
                end
            end
`ifdef ECG_CFG_CHKSUM_EN
            S_CHK: begin
                if (cfg_en_i) begin
                    state_nxt = (cfg_data_i == chksum) ? S_STRM : S_ERR;
                end
            end
`endif
            S_STRM: state_nxt = S_STRM;
            S_ERR:  state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
    end

    // ------------------------------------------------------------------
    // Parameter write port, length latch and sticky status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prm_we_o   <= 1'b0;
            prm_addr_o <= '0;
            prm_data_o <= '0;
            prm_cnt    <= '0;
            prm_len    <= '0;
            cfg_ok_o   <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            prm_we_o <= 1'b0;
            if (state == S_LEN && cfg_en_i) begin
                // Only meaningful when the length is in range; an
                // out-of-range value sends the FSM to ERR anyway.
                prm_len <= cfg_data_i[PRM_AW:0];
                prm_cnt <= '0;
            end
            if (state == S_PRM && cfg_en_i) begin
                prm_we_o   <= 1'b1;
                prm_addr_o <= prm_cnt[PRM_AW-1:0];
                prm_data_o <= cfg_data_i;
                prm_cnt    <= prm_cnt + PRM_ONE;
            end
            if (state != S_STRM && state_nxt == S_STRM) begin
                cfg_ok_o <= 1'b1;
            end
            if (state != S_ERR && state_nxt == S_ERR) begin
                cfg_err_o <= 1'b1;
            end
        end
    end

`ifdef ECG_CFG_CHKSUM_EN
    // Sum of parameter words only, wrapping modulo 2^DATA_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chksum <= '0;
        end else if (state == S_PRM && cfg_en_i) begin
            chksum <= chksum + cfg_data_i;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[LOG2_FIFO] != rd_ptr[LOG2_FIFO]) &&
                        (wr_ptr[LOG2_FIFO-1:0] == rd_ptr[LOG2_FIFO-1:0]);

    assign push_req = (state == S_STRM) && ecg_en_i;
    assign pop      = !fifo_empty && smp_ready_i;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    assign smp_valid_o = !fifo_empty;
    // Head is forced to zero while empty so stale storage never shows.
    assign smp_data_o  = fifo_empty ? '0 : mem[rd_ptr[LOG2_FIFO-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[LOG2_FIFO-1:0]] <= ecg_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ovf_o     <= 1'b0;
            smp_cnt_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (drop) begin
                ovf_o <= 1'b1;
            end
            if (push && smp_cnt_o != CNT_MAX) begin
                smp_cnt_o <= smp_cnt_o + CNT_ONE;
            end
        end
    end

endmodule
